key_press_classifier: RTL and testbench

//  Per-key front end for the front-panel push buttons. Synchronises raw inputs, debounces them and classifies each press.

---
 rtl/key_pkg.sv | 28 ++
 rtl/key_fsm_single.sv | 164 ++++++++++++++++
 rtl/key_press_classifier.sv | 36 +++
 tb/tb_key_press_classifier.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and timing constants for the front-panel key classifier.
// Board values assume a 100 MHz clk; SIM_* values are scaled for short simulations.
package key_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DB_PRESS = 3'd1,
        ST_PRESSED  = 3'd2,
        ST_LONG     = 3'd3,
        ST_DB_REL   = 3'd4
    } key_state_e;

    localparam int unsigned DEF_NUM_KEYS       = 4;

    localparam int unsigned BOARD_DEBOUNCE_CYC = 2_000_000;
    localparam int unsigned BOARD_LONG_CYC     = 50_000_000;
    localparam int unsigned BOARD_REPEAT_CYC   = 20_000_000;

    localparam int unsigned SIM_DEBOUNCE_CYC   = 4;
    localparam int unsigned SIM_LONG_CYC       = 20;
    localparam int unsigned SIM_REPEAT_CYC     = 8;

    // Counter width able to hold max_val; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_fsm_single.sv
// One key: 2-FF synchroniser, debounce counter and press-classification FSM.
// Latency: 2 sync cycles + DEBOUNCE_CYC samples to a level change; all outputs registered, no backpressure.
module key_fsm_single
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = SIM_DEBOUNCE_CYC,
    parameter int unsigned LONG_CYC     = SIM_LONG_CYC,
    parameter int unsigned REPEAT_CYC   = SIM_REPEAT_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw_i,
    output logic level_o,
    output logic short_o,
    output logic long_o,
    output logic repeat_o
);

    localparam int unsigned DCNT_W = cnt_w(DEBOUNCE_CYC);
    localparam int unsigned HCNT_W = cnt_w(LONG_CYC);
    localparam int unsigned RPT_W  = cnt_w(REPEAT_CYC);

    localparam logic [DCNT_W-1:0] DB_LIM   = DCNT_W'(DEBOUNCE_CYC);
    localparam logic [HCNT_W-1:0] LONG_LIM = HCNT_W'(LONG_CYC);
    localparam logic [RPT_W-1:0]  RPT_LIM  = RPT_W'(REPEAT_CYC);

    logic [1:0]        sync_q;
    key_state_e        state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic [RPT_W-1:0]  rpt_q, rpt_d;
    logic              tag_long_q, tag_long_d;
    logic              level_q, level_d;
    logic              short_q, short_d;
    logic              long_q, long_d;
    logic              repeat_q, repeat_d;

    logic              key_s;
    logic              held_long;
    logic [DCNT_W-1:0] dcnt_inc;
    logic [HCNT_W-1:0] hcnt_inc;
    logic [RPT_W-1:0]  rpt_inc;

    assign key_s    = sync_q[1];
    assign dcnt_inc = dcnt_q + DCNT_W'(1);
    assign hcnt_inc = hcnt_q + HCNT_W'(1);
    assign rpt_inc  = rpt_q + RPT_W'(1);

    // A bounce during release keeps the long/short tag of the state it left.
    assign held_long = (state_q == ST_LONG) || ((state_q == ST_DB_REL) && tag_long_q);

    always_comb begin
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        hcnt_d     = hcnt_q;
        rpt_d      = rpt_q;
        tag_long_d = tag_long_q;
        level_d    = level_q;
        short_d    = 1'b0;
        long_d     = 1'b0;
        repeat_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DB_PRESS: begin
                if (key_s) begin
                    if (dcnt_inc == DB_LIM) begin
                        state_d    = ST_PRESSED;
                        level_d    = 1'b1;
                        dcnt_d     = '0;
                        hcnt_d     = '0;
                        tag_long_d = 1'b0;
                    end else begin
                        state_d = ST_DB_PRESS;
                        dcnt_d  = dcnt_inc;
                    end
                end else begin
                    state_d = ST_IDLE;
                    dcnt_d  = '0;
                end
            end

            ST_PRESSED, ST_LONG, ST_DB_REL: begin
                if (key_s) begin
                    // A high sample is hold time, including the one ending a release bounce.
                    dcnt_d = '0;
                    if (held_long) begin
                        state_d = ST_LONG;
                        if (REPEAT_CYC != 0) begin
                            if (rpt_inc == RPT_LIM) begin
                                repeat_d = 1'b1;
                                rpt_d    = '0;
                            end else begin
                                rpt_d = rpt_inc;
                            end
                        end
                    end else if (hcnt_inc == LONG_LIM) begin
                        state_d = ST_LONG;
                        hcnt_d  = hcnt_inc;
                        long_d  = 1'b1;
                        rpt_d   = '0;
                    end else begin
                        state_d = ST_PRESSED;
                        hcnt_d  = hcnt_inc;
                    end
                end else begin
                    tag_long_d = held_long;
                    if (dcnt_inc == DB_LIM) begin
                        state_d    = ST_IDLE;
                        level_d    = 1'b0;
                        short_d    = !held_long;
                        dcnt_d     = '0;
                        hcnt_d     = '0;
                        rpt_d      = '0;
                        tag_long_d = 1'b0;
                    end else begin
                        state_d = ST_DB_REL;
                        dcnt_d  = dcnt_inc;
                    end
                end
            end

            default: begin
                state_d    = ST_IDLE;
                dcnt_d     = '0;
                hcnt_d     = '0;
                rpt_d      = '0;
                tag_long_d = 1'b0;
                level_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            state_q    <= ST_IDLE;
            dcnt_q     <= '0;
            hcnt_q     <= '0;
            rpt_q      <= '0;
            tag_long_q <= 1'b0;
            level_q    <= 1'b0;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], key_raw_i};
            state_q    <= state_d;
            dcnt_q     <= dcnt_d;
            hcnt_q     <= hcnt_d;
            rpt_q      <= rpt_d;
            tag_long_q <= tag_long_d;
            level_q    <= level_d;
            short_q    <= short_d;
            long_q     <= long_d;
            repeat_q   <= repeat_d;
        end
    end

    assign level_o  = level_q;
    assign short_o  = short_q;
    assign long_o   = long_q;
    assign repeat_o = repeat_q;

endmodule

// File: rtl/key_press_classifier.sv
// Front-panel key front end: NUM_KEYS independent debounce/classify channels.
// Latency: 2 sync cycles + DEBOUNCE_CYC samples to level; pulses registered, 1 clk wide, no backpressure.
module key_press_classifier
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS     = DEF_NUM_KEYS,
    parameter int unsigned DEBOUNCE_CYC = BOARD_DEBOUNCE_CYC,
    parameter int unsigned LONG_CYC     = BOARD_LONG_CYC,
    parameter int unsigned REPEAT_CYC   = BOARD_REPEAT_CYC
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_short,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_repeat
);

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_fsm_single #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC),
            .REPEAT_CYC   (REPEAT_CYC)
        ) u_key (
            .clk       (clk),
            .rst_n     (rst_n),
            .key_raw_i (key_raw[k]),
            .level_o   (key_level[k]),
            .short_o   (key_short[k]),
            .long_o    (key_long[k]),
            .repeat_o  (key_repeat[k])
        );
    end

endmodule

// File: tb/tb_key_press_classifier.sv
// Directed bench for key_press_classifier with scaled timing (debounce 4, long 20, repeat 8).
// Expected edge/pulse cycles are derived from each stimulus and matched against observed events.
module tb_key_press_classifier;
    import key_pkg::*;

    localparam int NK = 4;
    localparam int DB = 4;
    localparam int LG = 20;
    localparam int RP = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key_raw = '0;
    logic [NK-1:0] key_level, key_short, key_long, key_repeat;

    key_press_classifier #(
        .NUM_KEYS     (NK),
        .DEBOUNCE_CYC (DB),
        .LONG_CYC     (LG),
        .REPEAT_CYC   (RP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_raw    (key_raw),
        .key_level  (key_level),
        .key_short  (key_short),
        .key_long   (key_long),
        .key_repeat (key_repeat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_UP, EV_DN, EV_SHORT, EV_LONG, EV_RPT} ev_kind_e;
    typedef struct {
        int       at;
        int       key;
        ev_kind_e kind;
    } ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic void push_ev(int at, int k, ev_kind_e kd);
        exp_q.push_back('{at: at, key: k, kind: kd});
    endfunction

    // Raw goes high just after edge t0 for len cycles: sampled high on edges t0+3 .. t0+len+2.
    function automatic void expect_press(int k, int t0, int len);
        int hold;
        if (len < DB) return;
        push_ev(t0 + 2 + DB, k, EV_UP);
        hold = len - DB;
        if (hold >= LG) begin
            push_ev(t0 + 2 + DB + LG, k, EV_LONG);
            for (int t = t0 + 2 + DB + LG + RP; t <= t0 + len + 2; t += RP)
                push_ev(t, k, EV_RPT);
        end
        push_ev(t0 + len + 2 + DB, k, EV_DN);
        if (hold < LG) push_ev(t0 + len + 2 + DB, k, EV_SHORT);
    endfunction

    task automatic match_event(int k, ev_kind_e kd);
        int idx  = -1;
        int want = -1;
        foreach (exp_q[i])
            if (idx < 0 && exp_q[i].key == k && exp_q[i].kind == kd) idx = i;
        if (idx >= 0) begin
            want = exp_q[idx].at;
            exp_q.delete(idx);
        end
        check($sformatf("event key%0d %s cycle", k, kd.name()), cyc, want);
    endtask

    // Monitor: every level edge or pulse must match a pending expectation at the right cycle.
    logic [NK-1:0] prev_lvl = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_lvl = '0;
        end else begin
            for (int k = 0; k < NK; k++) begin
                if (key_level[k] !== prev_lvl[k]) match_event(k, key_level[k] ? EV_UP : EV_DN);
                if (key_short[k] !== 1'b0)  match_event(k, EV_SHORT);
                if (key_long[k] !== 1'b0)   match_event(k, EV_LONG);
                if (key_repeat[k] !== 1'b0) match_event(k, EV_RPT);
                if (key_short[k] || key_long[k])
                    check($sformatf("short_long_exclusive key%0d", k),
                          {31'd0, key_short[k] & key_long[k]}, 32'd0);
            end
            prev_lvl = key_level;
        end
    end

    task automatic wait_cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(int k, int len);
        int t0;
        key_raw[k] = 1'b1;
        t0 = cyc;
        expect_press(k, t0, len);
        wait_cyc(len);
        key_raw[k] = 1'b0;
        wait_cyc(14);
    endtask

    initial begin
        int t0;

        wait_cyc(3);
        check("reset key_level",  {28'd0, key_level},  32'd0);
        check("reset key_short",  {28'd0, key_short},  32'd0);
        check("reset key_long",   {28'd0, key_long},   32'd0);
        check("reset key_repeat", {28'd0, key_repeat}, 32'd0);
        rst_n = 1'b1;
        wait_cyc(4);

        // Glitch of 3 samples: nothing may move.
        key_raw[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) key_raw[0] = 1'b0;
            check("glitch outputs quiet", {16'd0, key_level, key_short, key_long, key_repeat}, 32'd0);
            @(negedge clk);
        end

        press(0, 10);   // short press
        press(0, 4);    // exactly DEBOUNCE_CYC high samples: accepted, zero hold
        press(1, 50);   // long, repeats every 8 samples while still held
        press(2, 23);   // hold 19: short
        press(2, 24);   // hold reaches 20 on the last high sample: long wins, no short

        // Release bounce: 2 low samples mid-hold are frozen, total hold 12 -> short.
        key_raw[0] = 1'b1;
        t0 = cyc;
        push_ev(t0 + 6, 0, EV_UP);
        push_ev(t0 + 24, 0, EV_DN);
        push_ev(t0 + 24, 0, EV_SHORT);
        wait_cyc(8);
        key_raw[0] = 1'b0;
        wait_cyc(2);
        key_raw[0] = 1'b1;
        wait_cyc(8);
        key_raw[0] = 1'b0;
        wait_cyc(14);

        // All keys together with lengths 10/25/10/40; key 3 is reset mid-hold after its first repeat.
        key_raw = '1;
        t0 = cyc;
        expect_press(0, t0, 10);
        expect_press(1, t0, 25);
        expect_press(2, t0, 10);
        push_ev(t0 + 6,  3, EV_UP);
        push_ev(t0 + 26, 3, EV_LONG);
        push_ev(t0 + 34, 3, EV_RPT);
        wait_cyc(10);
        key_raw[0] = 1'b0;
        key_raw[2] = 1'b0;
        wait_cyc(15);
        key_raw[1] = 1'b0;
        wait_cyc(13);
        check("key3 level held before reset", {31'd0, key_level[3]}, 32'd1);
        key_raw[3] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async reset key_level",  {28'd0, key_level},  32'd0);
        check("async reset key_short",  {28'd0, key_short},  32'd0);
        check("async reset key_long",   {28'd0, key_long},   32'd0);
        check("async reset key_repeat", {28'd0, key_repeat}, 32'd0);
        check("pending before reset", exp_q.size(), 32'd0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(30);

        check("no outstanding expectations", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
